// File: rtl/interleaver_ctrl.sv
// rtl/interleaver_ctrl.sv - write/read sequencing controller for a block interleaver buffer
//
// Fills an interleaver buffer with one block of L bits (write indices 0..L-1),
// then drains it (read indices 0..L-1, fed to the index generator), then pulses
// done. L is N_SMALL or N_LARGE, selected by k captured at start.
//
// Ports:
//   clock, reset_n     system clock, asynchronous active-low reset
//   start, k           block-start request and block-size select (IDLE only)
//   abort              synchronous abort back to IDLE, highest priority
//   in_valid           one input bit available (WRITE phase)
//   out_ready          downstream accepts one output bit (READ phase)
//   busy, k_lat        not-IDLE flag, latched block-size select
//   wr_en, wr_addr     buffer write strobe and index
//   rd_en, rd_addr     buffer read strobe and index
//   out_valid          rd_en delayed by the one-cycle memory read latency
//   done               one-cycle pulse at block completion
module interleaver_ctrl #(
  parameter int N_SMALL = 1056,
  parameter int N_LARGE = 6144,
  parameter int AW      = 13
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          k,
  input  logic          abort,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          k_lat,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          out_valid,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_SMALL = AW'(N_SMALL - 1);
  localparam logic [AW-1:0] LAST_LARGE = AW'(N_LARGE - 1);
  localparam logic [AW-1:0] ADDR_ONE   = AW'(1);

  state_t        state;
  logic [AW-1:0] last_addr;

  // Block length follows the latched select only, so k may change freely mid-block.
  assign last_addr = k_lat ? LAST_LARGE : LAST_SMALL;

  assign wr_en = (state == S_WRITE) && in_valid;
  assign rd_en = (state == S_READ) && out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      k_lat     <= 1'b0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else if (abort) begin
      // k_lat is deliberately kept: it only describes the last accepted start.
      state     <= S_IDLE;
      wr_addr   <= '0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= rd_en;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_WRITE;
            busy    <= 1'b1;
            k_lat   <= k;
            wr_addr <= '0;
            rd_addr <= '0;
          end
        end
        S_WRITE: begin
          // The final index is held rather than wrapped so the address never exceeds L-1.
          if (in_valid) begin
            if (wr_addr == last_addr) begin
              state <= S_READ;
            end else begin
              wr_addr <= wr_addr + ADDR_ONE;
            end
          end
        end
        S_READ: begin
          if (out_ready) begin
            if (rd_addr == last_addr) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              rd_addr <= rd_addr + ADDR_ONE;
            end
          end
        end
        S_DONE: begin
          // start is not looked at here; a new block can only begin from IDLE.
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interleaver_ctrl.sv
// tb/tb_interleaver_ctrl.sv - self-checking bench for interleaver_ctrl
module tb_interleaver_ctrl;

  localparam int N_SMALL = 1056;
  localparam int N_LARGE = 6144;
  localparam int AW      = 13;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic          k;
  logic          abort;
  logic          in_valid;
  logic          out_ready;
  logic          busy;
  logic          k_lat;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          out_valid;
  logic          done;

  int n_vec = 0;
  int n_err = 0;
  int tick  = 0;

  int rd_q[$];
  int ov_q[$];

  interleaver_ctrl #(
    .N_SMALL(N_SMALL),
    .N_LARGE(N_LARGE),
    .AW(AW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .k(k),
    .abort(abort),
    .in_valid(in_valid),
    .out_ready(out_ready),
    .busy(busy),
    .k_lat(k_lat),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .out_valid(out_valid),
    .done(done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) tick <= tick + 1;

  initial begin
    #950000;
    $display("FAIL timeout: simulation exceeded its cycle budget");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // out_valid scoreboard: each accepted read is expected to show out_valid exactly one cycle later.
  task automatic check_ov();
    if (ov_q.size() > 0 && ov_q[0] == tick) begin
      chk("out_valid_hi", out_valid, 1);
      void'(ov_q.pop_front());
    end else begin
      chk("out_valid_lo", out_valid, 0);
    end
  endtask

  task automatic run_block(input logic kk, input int gap, input logic hold);
    int len;
    int ew;
    int er;
    int cyc;
    int nwr;
    int nrd;
    len = kk ? N_LARGE : N_SMALL;
    ew = 0; er = 0; cyc = 0; nwr = 0; nrd = 0;
    start = 1'b1; k = kk; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    @(posedge clock); #1;
    if (!hold) start = 1'b0;
    while (ew < len && cyc < 4 * len) begin
      in_valid = ($urandom_range(99) >= gap);
      k = 1'($urandom_range(1));
      @(negedge clock);
      check_ov();
      chk("wr_busy", busy, 1);
      chk("wr_en", wr_en, in_valid);
      chk("wr_addr", wr_addr, ew);
      if (wr_en) nwr++;
      if (in_valid) ew++;
      cyc++;
      @(posedge clock); #1;
    end
    chk("wr_done_in_budget", ew, len);
    chk("wr_count", nwr, len);
    in_valid = 1'b0;
    cyc = 0;
    while (er < len && cyc < 4 * len) begin
      out_ready = ($urandom_range(99) >= gap);
      in_valid = 1'($urandom_range(1));
      k = 1'($urandom_range(1));
      if (out_ready) begin
        rd_q.push_back(er);
        ov_q.push_back(tick + 1);
      end
      @(negedge clock);
      check_ov();
      chk("rd_en", rd_en, out_ready);
      chk("rd_wr_en", wr_en, 0);
      chk("rd_wr_addr_hold", wr_addr, len - 1);
      chk("rd_k_lat", k_lat, kk);
      if (rd_en) begin
        nrd++;
        chk("rd_sb_depth", rd_q.size() > 0, 1);
        if (rd_q.size() > 0) chk("rd_addr", rd_addr, rd_q.pop_front());
      end
      if (out_ready) er++;
      cyc++;
      @(posedge clock); #1;
    end
    chk("rd_done_in_budget", er, len);
    chk("rd_count", nrd, len);
    chk("rd_sb_empty", rd_q.size(), 0);
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check_ov();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_rd_addr", rd_addr, len - 1);
    chk("done_wr_addr", wr_addr, len - 1);
    chk("done_k_lat", k_lat, kk);
    @(posedge clock); #1;
    @(negedge clock);
    check_ov();
    chk("after_done_pulse", done, 0);
    chk("after_done_busy", busy, 0);
    chk("ov_sb_empty", ov_q.size(), 0);
  endtask

  typedef struct {
    logic st, kk, ab, iv, orr;
    logic e_busy, e_k_lat, e_wr_en, e_rd_en, e_ov, e_done;
    int   e_wa, e_ra;
  } vec_t;

  vec_t vt[13];

  initial begin
    // inputs driven after an edge, outputs checked before the next edge
    vt[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 0,0};
    vt[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 0,0};
    vt[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 0,0};
    vt[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 0,0};
    vt[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1,0};
    vt[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 1,0};
    vt[6]  = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2,0};
    vt[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 3,0};
    vt[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 0,0};
    vt[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 0,0};
    vt[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 0,0};
    vt[11] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 0,0};
    vt[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 0,0};

    reset_n = 1'b0; start = 1'b0; k = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_k_lat", k_lat, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(posedge clock); #1;
      start = vt[i].st; k = vt[i].kk; abort = vt[i].ab;
      in_valid = vt[i].iv; out_ready = vt[i].orr;
      @(negedge clock);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("vec%0d_k_lat", i), k_lat, vt[i].e_k_lat);
      chk($sformatf("vec%0d_wr_en", i), wr_en, vt[i].e_wr_en);
      chk($sformatf("vec%0d_rd_en", i), rd_en, vt[i].e_rd_en);
      chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_ov);
      chk($sformatf("vec%0d_done", i), done, vt[i].e_done);
      chk($sformatf("vec%0d_wr_addr", i), wr_addr, vt[i].e_wa);
      chk($sformatf("vec%0d_rd_addr", i), rd_addr, vt[i].e_ra);
    end
    @(posedge clock); #1;
    start = 1'b0; k = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // small block, continuous flow, k toggled mid-block
    run_block(1'b0, 0, 1'b0);

    // large block with random gaps on both sides
    run_block(1'b1, 30, 1'b0);

    // abort at wr_addr=500, then a normal large block
    start = 1'b1; k = 1'b0;
    @(posedge clock); #1;
    start = 1'b0; in_valid = 1'b1;
    repeat (500) @(posedge clock);
    #1;
    abort = 1'b1; start = 1'b1; k = 1'b1;
    @(negedge clock);
    chk("abort_at_wr_addr", wr_addr, 500);
    chk("abort_wr_en", wr_en, 1);
    @(posedge clock); #1;
    abort = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("abort_busy", busy, 0);
    chk("abort_wr_addr", wr_addr, 0);
    chk("abort_rd_addr", rd_addr, 0);
    chk("abort_done", done, 0);
    chk("abort_k_lat", k_lat, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("abort_no_done", done, 0);
    run_block(1'b1, 0, 1'b0);

    // asynchronous reset during READ at rd_addr=300
    start = 1'b1; k = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; in_valid = 1'b1;
    repeat (N_LARGE) @(posedge clock);
    #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (300) @(posedge clock);
    @(negedge clock);
    chk("pre_rst_rd_addr", rd_addr, 300);
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_k_lat", k_lat, 1);
    #1;
    reset_n = 1'b0; start = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_k_lat", k_lat, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_rd_addr", rd_addr, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_done", done, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_start_ignored", busy, 0);
    reset_n = 1'b1; start = 1'b1; k = 1'b1; out_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("first_start_busy", busy, 1);
    chk("first_start_k_lat", k_lat, 1);
    chk("first_start_wr_addr", wr_addr, 0);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    chk("post_rst_abort_busy", busy, 0);

    // start held high through the whole block
    run_block(1'b0, 0, 1'b1);
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("held_start_new_block", busy, 1);
    chk("held_start_wr_addr", wr_addr, 0);
    chk("held_start_rd_addr", rd_addr, 0);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    chk("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
